// File: rtl/traffic_demand_scheduler.sv
// Debounces per-direction vehicle sensors, latches demand and offers
// the next direction round-robin (N,S,E,W) with an idle north recall.
module traffic_demand_scheduler #(
  parameter int DEB_CYC  = 4,
  parameter int IDLE_CYC = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sensor,
  input  logic       dir_ack,
  output logic       dir_valid,
  output logic [1:0] dir,
  output logic       recall,
  output logic [3:0] pending,
  output logic [3:0] sensor_filt
);

  localparam logic [3:0] DEB_MAX  = 4'(DEB_CYC - 1);
  localparam logic [7:0] IDLE_MAX = 8'(IDLE_CYC - 1);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t          state, state_n;
  logic [3:0][3:0] cnt, cnt_n;
  logic [3:0]      filt_n;
  logic [3:0]      rise;
  logic [3:0]      clr;
  logic [3:0]      pend_n;
  logic [1:0]      ptr, ptr_n;
  logic [1:0]      dir_n;
  logic            rec_n;
  logic [7:0]      idle, idle_n;
  logic [7:0]      dbl;
  logic [3:0]      rot;
  logic [1:0]      off;
  logic [1:0]      pick;

  assign dir_valid = (state == OFFER);

  always_comb begin
    cnt_n  = cnt;
    filt_n = sensor_filt;
    rise   = '0;
    for (int i = 0; i < 4; i++) begin
      if (sensor[i] == sensor_filt[i]) begin
        cnt_n[i] = '0;
      end else if (cnt[i] == DEB_MAX) begin
        cnt_n[i]  = '0;
        filt_n[i] = ~sensor_filt[i];
        rise[i]   = ~sensor_filt[i];
      end else begin
        cnt_n[i] = cnt[i] + 4'd1;
      end
    end
  end

  // a fresh rise beats the clear of the bit being acked
  assign clr = (dir_valid && dir_ack && !recall)
             ? (4'b0001 << dir) : 4'b0000;
  assign pend_n = (pending & ~clr) | rise;

  assign dbl = {pending, pending} >> ptr;
  assign rot = dbl[3:0];

  always_comb begin
    off = 2'd3;
    priority case (1'b1)
      rot[0]:  off = 2'd0;
      rot[1]:  off = 2'd1;
      rot[2]:  off = 2'd2;
      default: off = 2'd3;
    endcase
  end

  assign pick = ptr + off;

  always_comb begin
    state_n = state;
    dir_n   = dir;
    rec_n   = recall;
    ptr_n   = ptr;
    idle_n  = idle;
    unique case (state)
      IDLE: begin
        if (|pending) begin
          dir_n   = pick;
          rec_n   = 1'b0;
          state_n = OFFER;
          idle_n  = '0;
        end else if (idle == IDLE_MAX) begin
          dir_n   = 2'd0;
          rec_n   = 1'b1;
          state_n = OFFER;
          idle_n  = '0;
        end else begin
          idle_n = idle + 8'd1;
        end
      end
      OFFER: begin
        idle_n = '0;
        if (dir_ack) begin
          state_n = IDLE;
          rec_n   = 1'b0;
          if (!recall) ptr_n = dir + 2'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      sensor_filt <= '0;
      pending     <= '0;
      dir         <= '0;
      recall      <= 1'b0;
      ptr         <= '0;
      idle        <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      sensor_filt <= filt_n;
      pending     <= pend_n;
      dir         <= dir_n;
      recall      <= rec_n;
      ptr         <= ptr_n;
      idle        <= idle_n;
    end
  end

endmodule

// File: tb/tb_traffic_demand_scheduler.sv
// Self-checking bench for traffic_demand_scheduler against a
// behavioural model of the debounce, demand and offer rules.
module tb_traffic_demand_scheduler;

  localparam int DEB  = 4;
  localparam int IDLE = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sensor;
  logic       dir_ack;
  logic       dir_valid;
  logic [1:0] dir;
  logic       recall;
  logic [3:0] pending;
  logic [3:0] sensor_filt;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [3:0] m_filt;
  logic [3:0] m_pend;
  int         m_run [4];
  bit         m_off;
  bit         m_rec;
  int         m_dir;
  int         m_ptr;
  int         m_idle;

  logic [11:0] got, exp_v;

  traffic_demand_scheduler #(.DEB_CYC(DEB), .IDLE_CYC(IDLE)) dut (
    .clk(clk), .rst(rst), .sensor(sensor), .dir_ack(dir_ack),
    .dir_valid(dir_valid), .dir(dir), .recall(recall),
    .pending(pending), .sensor_filt(sensor_filt)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_filt = '0;
    m_pend = '0;
    for (int i = 0; i < 4; i++) m_run[i] = 0;
    m_off  = 0;
    m_rec  = 0;
    m_dir  = 0;
    m_ptr  = 0;
    m_idle = 0;
  endfunction

  function automatic void model_step(logic [3:0] s, logic a);
    logic [3:0] rose;
    logic [3:0] old_p;
    bit         hit;
    bit         found;
    int         j;
    rose  = '0;
    old_p = m_pend;
    hit   = m_off && a;
    for (int i = 0; i < 4; i++) begin
      if (s[i] !== m_filt[i]) begin
        m_run[i] = m_run[i] + 1;
        if (m_run[i] == DEB) begin
          m_filt[i] = s[i];
          m_run[i]  = 0;
          rose[i]   = s[i];
        end
      end else begin
        m_run[i] = 0;
      end
    end
    if (hit && !m_rec) m_pend[m_dir] = 1'b0;
    m_pend = m_pend | rose;
    if (!m_off) begin
      if (old_p != 0) begin
        found = 0;
        for (int k = 0; k < 4; k++) begin
          j = (m_ptr + k) % 4;
          if (!found && old_p[j]) begin
            found = 1;
            m_dir = j;
          end
        end
        m_rec  = 0;
        m_off  = 1;
        m_idle = 0;
      end else begin
        m_idle = m_idle + 1;
        if (m_idle == IDLE) begin
          m_dir  = 0;
          m_rec  = 1;
          m_off  = 1;
          m_idle = 0;
        end
      end
    end else begin
      m_idle = 0;
      if (a) begin
        m_off = 0;
        if (!m_rec) m_ptr = (m_dir + 1) % 4;
        m_rec = 0;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step(sensor, dir_ack);
    #1;
    got   = {dir_valid, dir, recall, pending, sensor_filt};
    exp_v = {m_off, 2'(m_dir), m_rec, m_pend, m_filt};
  endtask

  task automatic do_reset();
    rst     = 1'b0;
    sensor  = '0;
    dir_ack = 1'b0;
    model_reset();
    #3;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst     = 1'b0;
    sensor  = '0;
    dir_ack = 1'b0;
    #1;
    checks++;
    if ({dir_valid, dir, recall, pending, sensor_filt} !== 12'h000) begin
      errors++;
      $display("FAIL reset_state got=%h want=000",
               {dir_valid, dir, recall, pending, sensor_filt});
    end
    do_reset();
  endtask

  task automatic test_idle_recall();
    int rises [$];
    logic pv;
    do_reset();
    dir_ack = 1'b1;
    pv = 1'b0;
    for (int c = 1; c <= 70; c++) begin
      tick();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL recall_model c=%0d got=%h want=%h", c, got, exp_v);
      end
      if (dir_valid && !pv) begin
        rises.push_back(c);
        checks++;
        if (recall !== 1'b1 || dir !== 2'd0 || pending !== 4'd0) begin
          errors++;
          $display("FAIL recall_offer c=%0d rec=%b dir=%0d pend=%b want 1/0/0",
                   c, recall, dir, pending);
        end
      end
      pv = dir_valid;
    end
    checks++;
    if (rises.size() != 2 || rises[0] != IDLE
        || rises[1] != 2 * IDLE + 1) begin
      errors++;
      $display("FAIL recall_timing n=%0d first=%0d want %0d,%0d",
               rises.size(), rises.size() > 0 ? rises[0] : -1,
               IDLE, 2 * IDLE + 1);
    end
  endtask

  task automatic test_glitch();
    do_reset();
    sensor = 4'b0100;
    for (int c = 0; c < 12; c++) begin
      if (c == 3) sensor = 4'b0000;
      tick();
      checks++;
      if (got !== exp_v || sensor_filt[2] !== 1'b0 || pending !== 4'd0
          || dir_valid !== 1'b0) begin
        errors++;
        $display("FAIL glitch c=%0d got=%h want=%h", c, got, exp_v);
      end
    end
  endtask

  task automatic test_two_demands();
    int seen [$];
    int vcnt;
    do_reset();
    sensor = 4'b1010;
    vcnt = 0;
    for (int c = 1; c <= 14; c++) begin
      dir_ack = (vcnt >= 1);
      tick();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL two_model c=%0d got=%h want=%h", c, got, exp_v);
      end
      if (dir_valid) begin
        if (vcnt == 0 && !recall) seen.push_back(int'(dir));
        vcnt++;
      end else vcnt = 0;
      if (c == DEB) begin
        checks++;
        if (pending !== 4'b1010) begin
          errors++;
          $display("FAIL two_pend_set got=%b want=1010", pending);
        end
      end
    end
    checks++;
    if (seen.size() != 2 || seen[0] != 1 || seen[1] != 3
        || pending !== 4'b0000) begin
      errors++;
      $display("FAIL two_order n=%0d pend=%b want 1,3 and 0000",
               seen.size(), pending);
    end
  endtask

  task automatic test_rr_wrap();
    int order [$];
    int at [$];
    logic pv;
    do_reset();
    sensor = 4'b0010;
    for (int c = 0; c < 4; c++) tick();
    sensor  = 4'b0000;
    dir_ack = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    sensor = 4'b1111;
    pv = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL rr_model c=%0d got=%h want=%h", c, got, exp_v);
      end
      if (dir_valid && !pv && !recall) begin
        order.push_back(int'(dir));
        at.push_back(c);
      end
      pv = dir_valid;
    end
    checks++;
    if (order.size() != 4 || order[0] != 2 || order[1] != 3
        || order[2] != 0 || order[3] != 1) begin
      errors++;
      $display("FAIL rr_order n=%0d want 2,3,0,1", order.size());
    end else begin
      checks++;
      if (at[1] - at[0] != 2 || at[2] - at[1] != 2
          || at[3] - at[2] != 2) begin
        errors++;
        $display("FAIL rr_gap got=%0d,%0d,%0d want 2,2,2",
                 at[1] - at[0], at[2] - at[1], at[3] - at[2]);
      end
    end
  endtask

  task automatic test_set_wins();
    int guard;
    do_reset();
    sensor = 4'b0010;
    guard = 0;
    while (!dir_valid && guard < 20) begin
      tick();
      guard++;
    end
    checks++;
    if (!dir_valid || dir !== 2'd1) begin
      errors++;
      $display("FAIL setwin_offer valid=%b dir=%0d want 1/1",
               dir_valid, dir);
    end
    sensor = 4'b0000;
    for (int c = 0; c < DEB; c++) tick();
    sensor = 4'b0010;
    for (int c = 0; c < DEB - 1; c++) tick();
    dir_ack = 1'b1;
    tick();
    dir_ack = 1'b0;
    checks++;
    if (pending !== 4'b0010 || dir_valid !== 1'b0 || got !== exp_v) begin
      errors++;
      $display("FAIL setwin_pend pend=%b valid=%b want 0010/0",
               pending, dir_valid);
    end
    tick();
    checks++;
    if (dir_valid !== 1'b1 || dir !== 2'd1 || recall !== 1'b0) begin
      errors++;
      $display("FAIL setwin_reoffer v=%b d=%0d r=%b want 1/1/0",
               dir_valid, dir, recall);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    sensor = 4'b0001;
    for (int c = 0; c < DEB + 1; c++) tick();
    sensor = 4'b0101;
    tick();
    tick();
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({dir_valid, dir, recall, pending, sensor_filt} !== 12'h000) begin
      errors++;
      $display("FAIL async_reset got=%h want=000",
               {dir_valid, dir, recall, pending, sensor_filt});
    end
    model_reset();
    sensor = 4'b0001;
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < DEB - 1; c++) tick();
    checks++;
    if (pending[0] !== 1'b0 || got !== exp_v) begin
      errors++;
      $display("FAIL rerun_early pend=%b want 0000", pending);
    end
    tick();
    checks++;
    if (pending !== 4'b0001 || sensor_filt !== 4'b0001) begin
      errors++;
      $display("FAIL rerun_set pend=%b filt=%b want 0001/0001",
               pending, sensor_filt);
    end
  endtask

  task automatic test_random();
    logic [3:0] tgt;
    do_reset();
    tgt = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(39) == 0) tgt[i] = ~tgt[i];
      sensor = tgt;
      for (int i = 0; i < 4; i++)
        if ($urandom_range(5) == 0) sensor[i] = ~tgt[i];
      dir_ack = 1'($urandom_range(1));
      tick();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL random c=%0d got=%h want=%h", c, got, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_recall();
    test_glitch();
    test_two_demands();
    test_rr_wrap();
    test_set_wins();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
